// File: rtl/data_rmw_bridge_if.sv
// rtl/data_rmw_bridge_if.sv - CPU data port and word memory port bundle for the RMW bridge
interface data_rmw_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [31:0]           cpu_writedata;
    logic [3:0]            cpu_byteenable;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [31:0]           cpu_readdata;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           mem_writedata;
    logic [31:0]           mem_readdata;
    logic [CNT_WIDTH-1:0]  rmw_count;
    logic                  err;

    // Bridge side: consumes CPU requests and memory read data
    modport slave (
        input  cpu_address, cpu_writedata, cpu_byteenable, cpu_read, cpu_write,
        input  mem_readdata,
        output cpu_readdata, stall,
        output mem_address, mem_read, mem_write, mem_writedata,
        output rmw_count, err
    );

    // Environment side: CPU and memory driving the bridge
    modport master (
        output cpu_address, cpu_writedata, cpu_byteenable, cpu_read, cpu_write,
        output mem_readdata,
        input  cpu_readdata, stall,
        input  mem_address, mem_read, mem_write, mem_writedata,
        input  rmw_count, err
    );
endinterface

// File: rtl/data_rmw_bridge.sv
// rtl/data_rmw_bridge.sv - byte-enable to read-modify-write bridge with load stall handshake
module data_rmw_bridge #(
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    data_rmw_bridge_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_WAIT   = 2'd1,
        RMW_MERGE = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    // Only the word part of the address is kept; byte offset never reaches memory
    logic [ADDR_WIDTH-3:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  err_q;
    logic [31:0]           merged;
    logic                  req_any;
    logic                  conflict;

    assign req_any  = bus.cpu_read | bus.cpu_write;
    assign conflict = bus.cpu_read & bus.cpu_write;

    // Lane merge of latched store data over the word just read back
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : bus.mem_readdata[8*i +: 8];
        end
    end

    // State, request latches, saturating RMW counter and sticky conflict flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_any) begin
                addr_q  <= bus.cpu_address[ADDR_WIDTH-1:2];
                wdata_q <= bus.cpu_writedata;
                be_q    <= bus.cpu_byteenable;
            end
            if (state_q == RMW_MERGE && cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (state_q == IDLE && conflict) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next state and all outputs; everything is forced to zero while reset is high
    always_comb begin
        state_d           = state_q;
        bus.cpu_readdata  = '0;
        bus.stall         = 1'b0;
        bus.mem_address   = '0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_writedata = '0;
        bus.rmw_count     = '0;
        bus.err           = 1'b0;
        if (!reset) begin
            bus.rmw_count = cnt_q;
            bus.err       = err_q;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_write) begin
                        // Write wins over a simultaneous read
                        bus.mem_address = {bus.cpu_address[ADDR_WIDTH-1:2], 2'b00};
                        if (bus.cpu_byteenable == 4'b1111) begin
                            bus.mem_write     = 1'b1;
                            bus.mem_writedata = bus.cpu_writedata;
                        end else if (bus.cpu_byteenable != 4'b0000) begin
                            bus.mem_read = 1'b1;
                            bus.stall    = 1'b1;
                            state_d      = RMW_MERGE;
                        end
                    end else if (bus.cpu_read) begin
                        bus.mem_address = {bus.cpu_address[ADDR_WIDTH-1:2], 2'b00};
                        bus.mem_read    = 1'b1;
                        bus.stall       = 1'b1;
                        state_d         = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    bus.mem_address  = {addr_q, 2'b00};
                    bus.cpu_readdata = bus.mem_readdata;
                    state_d          = IDLE;
                end
                RMW_MERGE: begin
                    bus.mem_address   = {addr_q, 2'b00};
                    bus.mem_write     = 1'b1;
                    bus.mem_writedata = merged;
                    state_d           = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_rmw_bridge.sv
// tb/tb_data_rmw_bridge.sv - self-checking bench for data_rmw_bridge
module tb_data_rmw_bridge;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_rmw_bridge_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();

    data_rmw_bridge #(.CNT_WIDTH(16), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Word memory with one-cycle read latency
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_writedata;
        if (bus.mem_read)  rd_q <= mem[bus.mem_address[9:2]];
    end
    assign bus.mem_readdata = rd_q;

    int checks = 0;
    int errors = 0;

    // Reference state: word array, completed partial stores, conflict flag
    logic [31:0] ref_mem [0:255];
    int          ref_count = 0;
    logic        ref_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // What the CPU should see: load value, cycles until stall clears
    task automatic model(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] exp_data, output int exp_cyc);
        int idx;
        idx = int'(a[9:2]);
        exp_data = 32'h0;
        exp_cyc = 1;
        if (rd && wr) ref_err = 1'b1;
        if (wr) begin
            if (be == 4'hF) begin
                ref_mem[idx] = wd;
            end else if (be != 4'h0) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
                ref_count++;
                exp_cyc = 2;
            end
        end else if (rd) begin
            exp_data = ref_mem[idx];
            exp_cyc = 2;
        end
    endtask

    task automatic idle_inputs();
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_address = 32'h0;
        bus.cpu_writedata = 32'h0;
        bus.cpu_byteenable = 4'h0;
    endtask

    // Issue one CPU request and hold it until stall is low at a sample point
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rdata, output int cyc);
        bit done;
        done = 0;
        rdata = 32'h0;
        cyc = 0;
        bus.cpu_read = rd;
        bus.cpu_write = wr;
        bus.cpu_address = a;
        bus.cpu_writedata = wd;
        bus.cpu_byteenable = be;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            cyc++;
            chk("strobe_exclusive", {31'h0, bus.mem_read & bus.mem_write}, 32'h0);
            if (!bus.stall) begin
                rdata = bus.cpu_readdata;
                done = 1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL op_timeout: stall still %b after 8 cycles, required 0", bus.stall);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_cyc;
        int          exp_count;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] rdata;
        logic [31:0] exp_data;
        int cyc;
        int exp_cyc;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0] be;
        logic rd;
        logic wr;
        int op;

        // rd, wr, addr, wdata, be, exp_rdata, exp_cyc, exp_count
        vecs[0] = '{1'b0, 1'b1, 32'h100, 32'h12345678, 4'hF, 32'h0,        1, 0};
        vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 32'h12345678, 2, 0};
        vecs[2] = '{1'b0, 1'b1, 32'h100, 32'hAABBCCDD, 4'hF, 32'h0,        1, 0};
        vecs[3] = '{1'b0, 1'b1, 32'h100, 32'h00EE0000, 4'h4, 32'h0,        2, 1};
        vecs[4] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 32'hAAEECCDD, 2, 1};
        vecs[5] = '{1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, 32'h0,        1, 1};
        vecs[6] = '{1'b1, 1'b0, 32'h103, 32'h0,        4'hF, 32'hAAEECCDD, 2, 1};
        vecs[7] = '{1'b0, 1'b1, 32'h106, 32'h5A5A0000, 4'hC, 32'h0,        2, 2};
        vecs[8] = '{1'b1, 1'b0, 32'h104, 32'h0,        4'h0, 32'h5A5A0000, 2, 2};

        // Reset with a live full-word store on the bus: nothing may leak out
        bus.cpu_read = 1'b1;
        bus.cpu_write = 1'b1;
        bus.cpu_address = 32'h100;
        bus.cpu_writedata = 32'hDEADBEEF;
        bus.cpu_byteenable = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_write", {31'h0, bus.mem_write}, 32'h0);
        chk("reset_mem_read", {31'h0, bus.mem_read}, 32'h0);
        chk("reset_stall", {31'h0, bus.stall}, 32'h0);
        chk("reset_mem_address", bus.mem_address, 32'h0);
        chk("reset_mem_writedata", bus.mem_writedata, 32'h0);
        chk("reset_cpu_readdata", bus.cpu_readdata, 32'h0);
        chk("reset_rmw_count", {16'h0, bus.rmw_count}, 32'h0);
        chk("reset_err", {31'h0, bus.err}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();

        // Bring every memory word to a known value through the bridge
        for (int w = 0; w < 256; w++) begin
            model(1'b0, 1'b1, w * 4, 32'h0, 4'hF, exp_data, exp_cyc);
            do_op(1'b0, 1'b1, w * 4, 32'h0, 4'hF, rdata, cyc);
        end

        // Directed vectors, including sb followed back-to-back by lw
        for (int v = 0; v < 9; v++) begin
            model(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, exp_data, exp_cyc);
            do_op(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, rdata, cyc);
            chk($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
            chk($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cyc);
            chk($sformatf("vec%0d_rmw_count", v), {16'h0, bus.rmw_count}, vecs[v].exp_count);
        end

        // Halfword RMW with the live request replaced by garbage in the merge cycle
        model(1'b0, 1'b1, 32'h200, 32'hAABBCCDD, 4'hF, exp_data, exp_cyc);
        do_op(1'b0, 1'b1, 32'h200, 32'hAABBCCDD, 4'hF, rdata, cyc);
        bus.cpu_write = 1'b1;
        bus.cpu_address = 32'h201;
        bus.cpu_writedata = 32'h00001234;
        bus.cpu_byteenable = 4'h3;
        @(negedge clk);
        chk("hw_c0_stall", {31'h0, bus.stall}, 32'h1);
        chk("hw_c0_mem_read", {31'h0, bus.mem_read}, 32'h1);
        chk("hw_c0_mem_write", {31'h0, bus.mem_write}, 32'h0);
        chk("hw_c0_mem_address", bus.mem_address, 32'h200);
        @(posedge clk);
        #1;
        bus.cpu_address = 32'h3F0;
        bus.cpu_writedata = 32'hFFFFFFFF;
        bus.cpu_byteenable = 4'hF;
        @(negedge clk);
        chk("hw_c1_mem_write", {31'h0, bus.mem_write}, 32'h1);
        chk("hw_c1_mem_read", {31'h0, bus.mem_read}, 32'h0);
        chk("hw_c1_stall", {31'h0, bus.stall}, 32'h0);
        chk("hw_c1_mem_address", bus.mem_address, 32'h200);
        chk("hw_c1_mem_writedata", bus.mem_writedata, 32'hAABB1234);
        @(posedge clk);
        #1;
        idle_inputs();
        model(1'b0, 1'b1, 32'h200, 32'h00001234, 4'h3, exp_data, exp_cyc);
        chk("hw_rmw_count", {16'h0, bus.rmw_count}, ref_count);
        model(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, exp_data, exp_cyc);
        do_op(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, rdata, cyc);
        chk("hw_readback", rdata, 32'hAABB1234);

        // Reset asserted in the merge cycle: no write, counters cleared
        model(1'b0, 1'b1, 32'h240, 32'h11223344, 4'hF, exp_data, exp_cyc);
        do_op(1'b0, 1'b1, 32'h240, 32'h11223344, 4'hF, rdata, cyc);
        bus.cpu_write = 1'b1;
        bus.cpu_address = 32'h240;
        bus.cpu_writedata = 32'h000000FF;
        bus.cpu_byteenable = 4'h1;
        @(negedge clk);
        chk("rst_rmw_c0_stall", {31'h0, bus.stall}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rmw_mem_write", {31'h0, bus.mem_write}, 32'h0);
        chk("rst_rmw_stall", {31'h0, bus.stall}, 32'h0);
        chk("rst_rmw_count", {16'h0, bus.rmw_count}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        ref_count = 0;
        ref_err = 1'b0;
        @(negedge clk);
        chk("rst_rmw_idle_stall", {31'h0, bus.stall}, 32'h0);
        chk("rst_rmw_count_after", {16'h0, bus.rmw_count}, 32'h0);
        @(posedge clk);
        #1;
        do_op(1'b1, 1'b0, 32'h240, 32'h0, 4'h0, rdata, cyc);
        chk("rst_rmw_mem_unchanged", rdata, 32'h11223344);

        // Read and write together: write wins and err sticks
        model(1'b1, 1'b1, 32'h280, 32'hCAFEF00D, 4'hF, exp_data, exp_cyc);
        do_op(1'b1, 1'b1, 32'h280, 32'hCAFEF00D, 4'hF, rdata, cyc);
        chk("conflict_cycles", cyc, 1);
        chk("conflict_err", {31'h0, bus.err}, 32'h1);
        do_op(1'b1, 1'b0, 32'h280, 32'h0, 4'h0, rdata, cyc);
        chk("conflict_write_done", rdata, 32'hCAFEF00D);
        chk("conflict_err_sticky", {31'h0, bus.err}, 32'h1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
            wd = $urandom;
            rd = 1'b0;
            wr = 1'b1;
            be = 4'hF;
            case (op)
                0, 1:    be = 4'hF;
                2, 3, 4: be = 4'($urandom_range(1, 14));
                5, 6, 7: begin rd = 1'b1; wr = 1'b0; be = 4'($urandom_range(0, 15)); end
                8:       be = 4'h0;
                default: begin rd = 1'b1; be = 4'($urandom_range(0, 15)); end
            endcase
            model(rd, wr, a, wd, be, exp_data, exp_cyc);
            do_op(rd, wr, a, wd, be, rdata, cyc);
            chk($sformatf("rand%0d_rdata", n), rdata, exp_data);
            chk($sformatf("rand%0d_cycles", n), cyc, exp_cyc);
            chk($sformatf("rand%0d_rmw_count", n), {16'h0, bus.rmw_count}, ref_count);
            chk($sformatf("rand%0d_err", n), {31'h0, bus.err}, {31'h0, ref_err});
        end

        // Final reset clears the sticky flag
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("final_err_cleared", {31'h0, bus.err}, 32'h0);
        chk("final_count_cleared", {16'h0, bus.rmw_count}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end
endmodule

// File: doc/data_rmw_bridge.md
Name: data_rmw_bridge

Overview:
Sits between mips_cpu_harvard's data port and the word-only data_mem, directly downstream of the CPU's data_address/data_writedata/data_read/data_write outputs. It turns byte-enabled sub-word stores (sb/sh) into read-modify-write sequences and gives the memory's one-cycle read latency a stall handshake. Full-word stores pass through in a single cycle.

Parameters:
CNT_WIDTH, 16, width of the saturating RMW completion counter rmw_count.
ADDR_WIDTH, 32, width of CPU and memory byte addresses.

Ports:
clk  input  1  single system clock, all state changes on posedge.
reset  input  1  synchronous, active-high reset, sampled on posedge clk.
cpu_address  input  ADDR_WIDTH  byte address from the CPU.
cpu_writedata  input  32  store data, already placed in its byte lanes.
cpu_byteenable  input  4  lane enables; bit i covers bits [8i+7:8i].
cpu_read  input  1  load request.
cpu_write  input  1  store request.
cpu_readdata  output  32  load data, valid when cpu_read=1 and stall=0.
stall  output  1  CPU must hold its request and freeze while this is 1.
mem_address  output  ADDR_WIDTH  word-aligned address, equal to {addr[ADDR_WIDTH-1:2],2'b00}.
mem_read  output  1  memory read strobe; data returns on the next cycle.
mem_write  output  1  memory write strobe; the write is committed at posedge.
mem_writedata  output  32  full word to write.
mem_readdata  input  32  memory read data, valid one cycle after mem_read.
rmw_count  output  CNT_WIDTH  count of completed RMW stores, saturating.
err  output  1  sticky flag; set when cpu_read and cpu_write are both seen in IDLE.

Behaviour:
- States: IDLE, RD_WAIT, RMW_MERGE. A request is latched (address, writedata, byteenable) only when it is accepted in IDLE. Later states use the latched copies.
- IDLE, cpu_write with byteenable=4'b1111:
  - mem_write=1, mem_writedata=cpu_writedata, stall=0.
  - State stays IDLE. Latency is 1 cycle.
- IDLE, cpu_write with byteenable=4'b0000: no memory access, stall=0. This is a no-op.
- IDLE, cpu_write with a partial byteenable:
  - mem_read=1, stall=1.
  - Next state is RMW_MERGE.
- RMW_MERGE:
  - mem_write=1.
  - mem_writedata lane i = latched_be[i] ? latched_wdata lane i : mem_readdata lane i.
  - stall=0, rmw_count increments (holds at all-ones), next state is IDLE.
  - A partial store takes 2 cycles.
- IDLE, cpu_read:
  - mem_read=1, stall=1.
  - Next state is RD_WAIT.
- RD_WAIT:
  - cpu_readdata=mem_readdata, stall=0.
  - Next state is IDLE. A load takes 2 cycles.
  - Byteenable is ignored on reads; the CPU extracts lanes itself.
- cpu_read and cpu_write both high in IDLE: the write takes priority and follows the store rules. err is set and stays set until reset.
- stall is combinational from state and inputs. mem_* outputs are combinational from state and the latched or live request. No two memory strobes are ever high in the same cycle.
- A request that arrives in the cycle stall drops is accepted in the following cycle (back-to-back rule). The bridge adds no bubble beyond that IDLE cycle.
- cpu_readdata is 0 outside RD_WAIT.
- Reset, including mid-RD_WAIT or mid-RMW_MERGE:
  - state=IDLE; latches, rmw_count and err cleared.
  - No memory write is issued in the reset cycle.
  - All outputs are 0 while reset=1.
- mem_address low 2 bits are always 0. Address bits [1:0] from the CPU are ignored.

Test Plan:
- Full-word store: reset, then sw 0x12345678 to address 0x100 with be=1111 → mem_write=1 in the same cycle, stall=0, rmw_count=0; a following lw of 0x100 returns 0x12345678 after 2 cycles.
- Byte RMW: memory[0x100]=0xAABBCCDD; sb with wdata=0x00EE0000, be=0100 → cycle 0: stall=1, mem_read=1; cycle 1: mem_write=1, mem_writedata=0xAAEECCDD, stall=0; rmw_count=1.
- Halfword RMW with live inputs changed to garbage in cycle 1: be=0011, wdata=0x00001234 over 0xAABBCCDD → writes 0xAABB1234, proving the latched values are used.
- Back-to-back: an sb immediately followed by an lw of the same word → the lw sees the merged value; total 4 cycles; mem_read and mem_write are never high together.
- Reset mid-RMW: assert reset in the RMW_MERGE cycle → no mem_write, state=IDLE, stall=0, rmw_count=0, memory unchanged.
- Conflict and no-op: read+write both high with be=1111 → write executes, err=1 and stays 1 until reset; a store with be=0000 → no strobes, stall=0.
